// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline control-word types, widths and bubble constant
package pipe_pkg;

    localparam int PIPE_CTRL_W = 16;
    localparam int ALU_OP_W    = 4;
    localparam int PC_SRC_W    = 2;

    localparam int IFID_CTRL_W  = PIPE_CTRL_W;
    localparam int IDEX_CTRL_W  = PIPE_CTRL_W;
    localparam int EXMEM_CTRL_W = PIPE_CTRL_W;
    localparam int MEMWB_CTRL_W = PIPE_CTRL_W;

    typedef struct packed {
        logic        predTaken;
        logic [14:0] rsvd;
    } ifIdCtrl_t;

    typedef struct packed {
        logic                regWrite;
        logic                memWrite;
        logic                memRead;
        logic                memToReg;
        logic                aluSrc;
        logic [ALU_OP_W-1:0] aluOp;
        logic [PC_SRC_W-1:0] pcSrc;
        logic                branch;
        logic                jump;
        logic [2:0]          rsvd;
    } idExCtrl_t;

    typedef struct packed {
        logic        regWrite;
        logic        memWrite;
        logic        memRead;
        logic        memToReg;
        logic [11:0] rsvd;
    } exMemCtrl_t;

    typedef struct packed {
        logic        regWrite;
        logic        memToReg;
        logic [13:0] rsvd;
    } memWbCtrl_t;

    // A bubble must never write state downstream, so every control field is zero.
    localparam logic [PIPE_CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one pipeline slot: valid bit plus data/ctrl registers with load enable
module pipe_entry #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              loadEn,
    input  logic              validNext,
    input  logic [DATA_W-1:0] dataNext,
    input  logic [CTRL_W-1:0] ctrlNext,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else begin
            valid <= validNext;
            if (loadEn) begin
                data <= dataNext;
                ctrl <= ctrlNext;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with flush; PIPE_SKID_EN adds a skid entry
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CTRL_W = PIPE_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic              mainValid;
    logic [DATA_W-1:0] mainData;
    logic [CTRL_W-1:0] mainCtrl;
    logic              mainLoad;
    logic              mainValidNext;
    logic [DATA_W-1:0] mainDataNext;
    logic [CTRL_W-1:0] mainCtrlNext;
    logic              accept;
    logic              consume;

    assign consume = mainValid && out_ready;
    assign accept  = in_valid && in_ready;

`ifdef PIPE_SKID_EN
    logic              skidValid;
    logic [DATA_W-1:0] skidData;
    logic [CTRL_W-1:0] skidCtrl;
    logic              skidLoad;
    logic              skidValidNext;
    logic              mainFree;

    // in_ready comes straight from a flop so out_ready never reaches upstream combinationally.
    assign in_ready = !skidValid;
    assign mainFree = consume || !mainValid;

    always_comb begin
        mainLoad      = 1'b0;
        mainValidNext = mainValid;
        mainDataNext  = in_data;
        mainCtrlNext  = in_ctrl;
        skidLoad      = 1'b0;
        skidValidNext = skidValid;
        if (flush) begin
            mainValidNext = 1'b0;
            skidValidNext = 1'b0;
        end else if (mainFree) begin
            // An occupied skid always drains first; upstream is blocked while it is full.
            mainLoad      = skidValid || accept;
            mainValidNext = skidValid || accept;
            skidValidNext = 1'b0;
            if (skidValid) begin
                mainDataNext = skidData;
                mainCtrlNext = skidCtrl;
            end
        end else if (accept) begin
            skidLoad      = 1'b1;
            skidValidNext = 1'b1;
        end
    end

    pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) uSkid (
        .clk       (clk),
        .rst       (rst),
        .loadEn    (skidLoad),
        .validNext (skidValidNext),
        .dataNext  (in_data),
        .ctrlNext  (in_ctrl),
        .valid     (skidValid),
        .data      (skidData),
        .ctrl      (skidCtrl)
    );
`else
    assign in_ready = !mainValid || out_ready;

    always_comb begin
        mainDataNext  = in_data;
        mainCtrlNext  = in_ctrl;
        mainLoad      = accept && !flush;
        mainValidNext = mainValid;
        if (flush)
            mainValidNext = 1'b0;
        else if (accept)
            mainValidNext = 1'b1;
        else if (consume)
            mainValidNext = 1'b0;
    end
`endif

    pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) uMain (
        .clk       (clk),
        .rst       (rst),
        .loadEn    (mainLoad),
        .validNext (mainValidNext),
        .dataNext  (mainDataNext),
        .ctrlNext  (mainCtrlNext),
        .valid     (mainValid),
        .data      (mainData),
        .ctrl      (mainCtrl)
    );

    assign out_valid = mainValid;
    assign out_data  = mainData;
    assign out_ctrl  = mainValid ? mainCtrl : CTRL_W'(CTRL_NOP);

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic, parametrised pipeline stage register replacing the per-stage hand-written register blocks (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a wide data payload plus a control payload between stages. It adds valid/ready flow control, a synchronous flush for branch and jump squash, and bubble semantics: control is forced to zero whenever the stage holds no valid instruction. One instance sits on each stage boundary of the core pipeline.

## Interface
Parameters:
- DATA_W, 128, width of data payload (operands, register indices, offset); never zeroed except by reset
- CTRL_W, 16, width of control payload (RegWrite, MemWrite, MemRead, ALU op, PC source, ...); zeroed on bubble

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream stage presents an instruction
- in_ready  out  1  stage can accept an instruction this cycle
- in_data  in  DATA_W  upstream data payload
- in_ctrl  in  CTRL_W  upstream control payload
- flush  in  1  squash all held instructions and the incoming one
- out_valid  out  1  stage holds a valid instruction
- out_ready  in  1  downstream stage consumes the instruction this cycle
- out_data  out  DATA_W  held data payload
- out_ctrl  out  CTRL_W  held control payload; all-zero whenever out_valid=0

## Operation
- Accept: in_valid && in_ready at a rising edge. Consume: out_valid && out_ready at a rising edge.
- Ordering is strict FIFO. No instruction is duplicated or dropped, except by flush.
- Bubble: out_valid=0 forces out_ctrl=0. out_data keeps its last value.
- Flush (synchronous, sampled at the edge):
  - clears all entries' valid bits;
  - the same-cycle incoming instruction is discarded even if in_valid && in_ready;
  - flush beats accept and consume;
  - the cycle after a flush: out_valid=0, out_ctrl=0, in_ready=1.
- Downstream stall: out_ready=0 with out_valid=1 holds out_data and out_ctrl stable until consumed.
- out_valid never drops without a consume, flush or reset.
- Reset (any time, including mid-transfer): every entry invalid; out_valid=0, out_ctrl=0, out_data=0, in_ready=1. Takes effect immediately, with no clock needed.

## Timing
- Latency 1 cycle: an instruction accepted at edge N appears on out_* after edge N when the stage was empty or consumed at N.
- Throughput 1 instruction/cycle while out_ready=1.
- in_ready behaviour depends on configuration (below).
- No output depends combinationally on in_data or in_ctrl.

## Configuration
- Macro: PIPE_SKID_EN.
- Defined: 2 entries (main and skid).
  - in_ready is a registered signal: in_ready = !skid_valid. It has no combinational path from out_ready.
  - Accepting while main is full and not consumed writes the skid entry.
  - On consume, skid moves to main.
  - in_ready deasserts the cycle after the skid fills, and reasserts the cycle after it drains.
  - Full throughput is sustained across a one-cycle out_ready drop.
- Undefined: 1 entry.
  - in_ready = !out_valid || out_ready, combinational.
  - A simultaneous consume and accept replaces the entry in the same edge.

## Structure
- Shared package pipe_pkg holds:
  - per-stage control field widths and CTRL_W constants;
  - a packed struct typedef per stage control word;
  - the bubble constant CTRL_NOP = '0.
- One sub-module is natural: pipe_entry (valid bit, data and ctrl registers, async reset, load enable). It is instantiated once, or twice under PIPE_SKID_EN.

## Test plan
- Reset mid-stream: hold out_valid=1, ctrl=16'h00FF, assert rst between edges → out_valid=0, out_ctrl=0, out_data=0, in_ready=1 immediately.
- Streaming: in_valid=1 for 8 cycles with data 1..8, out_ready=1 → out_data 1..8 on consecutive cycles after 1-cycle latency, no gaps.
- Stall: out_ready=0 for 3 cycles with data=5 held.
  - Data and ctrl stay stable, with no loss.
  - With PIPE_SKID_EN: data=6 lands in skid, in_ready goes 0 next cycle, and 5 then 6 emerge once out_ready=1.
- Flush with accept: stage full with data 3, in_valid=1 with data 4, flush=1 at the same edge → next cycle out_valid=0, out_ctrl=0; neither 3 nor 4 ever appears.
- Bubble: in_valid=0 with in_ctrl=16'hFFFF, stage drained → out_ctrl=0 while out_valid=0.
- Random valid/ready and occasional flush for 10k cycles against a scoreboard: FIFO order kept, no duplicates, out_ctrl=0 whenever out_valid=0.
